// File: rtl/instruction_queue_pkg.sv
// Shared types and constants for the instruction queue.
// Holds boolean constants, the default depth and the buffered entry layout.
package instruction_queue_pkg;

    localparam bit TRUE  = 1'b1;
    localparam bit FALSE = 1'b0;

    localparam int ISQ_DEPTH_DEFAULT = 16;
    localparam int WORD_W            = 32;

    typedef struct packed {
        logic [WORD_W-1:0] ins;
        logic [WORD_W-1:0] pc;
        logic              predict;
    } isq_entry_t;

endpackage

// File: rtl/instruction_queue_if.sv
// Fetch-side inputs, back-pressure and issue outputs of the instruction queue.
// The queue uses the slave modport; the driver side uses master.
interface instruction_queue_if
    import instruction_queue_pkg::*;
;
    logic              rdy_in;
    logic              roll_back;
    logic              fetch_valid;
    logic [WORD_W-1:0] fetch_ins;
    logic [WORD_W-1:0] fetch_pc;
    logic              fetch_pc_predict;
    logic              rob_is_full;
    logic              rs_is_full;
    logic              lsb_is_full;
    logic              isq_full;
    logic              get_instruction;
    logic [WORD_W-1:0] isq_ins_out;
    logic [WORD_W-1:0] isq_pc_out;
    logic              isq_pc_predict;

    modport master (
        output rdy_in, roll_back, fetch_valid, fetch_ins, fetch_pc, fetch_pc_predict,
        output rob_is_full, rs_is_full, lsb_is_full,
        input  isq_full, get_instruction, isq_ins_out, isq_pc_out, isq_pc_predict
    );

    modport slave (
        input  rdy_in, roll_back, fetch_valid, fetch_ins, fetch_pc, fetch_pc_predict,
        input  rob_is_full, rs_is_full, lsb_is_full,
        output isq_full, get_instruction, isq_ins_out, isq_pc_out, isq_pc_predict
    );

endinterface

// File: rtl/instruction_queue_storage.sv
// Entry storage for the instruction queue: one write port, one asynchronous read port.
// Contents are never reset; validity is tracked entirely by the pointers in the parent.
module instruction_queue_storage
    import instruction_queue_pkg::*;
#(
    parameter int DEPTH = ISQ_DEPTH_DEFAULT,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_in,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  isq_entry_t    wr_data,
    input  logic [AW-1:0] rd_addr,
    output isq_entry_t    rd_data
);

    isq_entry_t mem_q [DEPTH];

    always_ff @(posedge clk_in) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Read before write: a same-cycle push into the head slot (full queue) sees the old entry.
    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/instruction_queue.sv
// In-order instruction queue between fetcher and reorder buffer / decoder.
// Optional one-cycle empty-queue bypass is enabled by defining ISQ_BYPASS_EN.
module instruction_queue
    import instruction_queue_pkg::*;
#(
    parameter int ISQ_DEPTH = ISQ_DEPTH_DEFAULT
) (
    input logic                clk_in,
    input logic                rst_n_in,
    instruction_queue_if.slave isq
);

    localparam int AW = $clog2(ISQ_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(ISQ_DEPTH);
    localparam logic [CW-1:0] FULL_C  = CW'(ISQ_DEPTH - 1);

    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] rear_q, rear_d;
    logic [CW-1:0] count_q, count_d;
    logic          get_q, get_d;
    isq_entry_t    out_q, out_d;

    isq_entry_t fetch_entry;
    isq_entry_t head_entry;
    logic       back_pressure;
    logic       do_issue;
    logic       do_bypass;
    logic       do_push;
    logic       wr_en;

    always_comb begin
        fetch_entry   = '{ins: isq.fetch_ins, pc: isq.fetch_pc, predict: isq.fetch_pc_predict};
        back_pressure = isq.rob_is_full | isq.rs_is_full | isq.lsb_is_full;
        do_issue      = (count_q != '0) && !back_pressure;
`ifdef ISQ_BYPASS_EN
        do_bypass     = (count_q == '0) && isq.fetch_valid && !back_pressure;
`else
        do_bypass     = FALSE;
`endif
        // A full queue still accepts a push when the head leaves in the same cycle.
        do_push       = isq.fetch_valid && !do_bypass && ((count_q < DEPTH_C) || do_issue);
        wr_en         = isq.rdy_in && !isq.roll_back && do_push;

        head_d  = head_q;
        rear_d  = rear_q;
        count_d = count_q;
        get_d   = get_q;
        out_d   = out_q;

        if (isq.rdy_in) begin
            if (isq.roll_back) begin
                head_d  = '0;
                rear_d  = '0;
                count_d = '0;
                get_d   = FALSE;
            end else begin
                get_d = (do_issue || do_bypass) ? TRUE : FALSE;
                if (do_issue) begin
                    out_d  = head_entry;
                    head_d = head_q + AW'(1);
                end else if (do_bypass) begin
                    out_d = fetch_entry;
                end
                if (do_push) begin
                    rear_d = rear_q + AW'(1);
                end
                case ({do_push, do_issue})
                    2'b10:   count_d = count_q + CW'(1);
                    2'b01:   count_d = count_q - CW'(1);
                    default: count_d = count_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            head_q  <= '0;
            rear_q  <= '0;
            count_q <= '0;
            get_q   <= FALSE;
            out_q   <= '0;
        end else begin
            head_q  <= head_d;
            rear_q  <= rear_d;
            count_q <= count_d;
            get_q   <= get_d;
            out_q   <= out_d;
        end
    end

    instruction_queue_storage #(
        .DEPTH (ISQ_DEPTH),
        .AW    (AW)
    ) u_storage (
        .clk_in  (clk_in),
        .wr_en   (wr_en),
        .wr_addr (rear_q),
        .wr_data (fetch_entry),
        .rd_addr (head_q),
        .rd_data (head_entry)
    );

    // One slot of headroom covers a push the fetcher already has in flight.
    assign isq.isq_full        = (count_q >= FULL_C);
    assign isq.get_instruction = get_q;
    assign isq.isq_ins_out     = out_q.ins;
    assign isq.isq_pc_out      = out_q.pc;
    assign isq.isq_pc_predict  = out_q.predict;

endmodule

// File: tb/tb_instruction_queue.sv
// Directed plus random stimulus for instruction_queue, checked against a queue-based model.
module tb_instruction_queue;

    localparam int DEPTH = 16;

    typedef struct packed {
        logic [31:0] ins;
        logic [31:0] pc;
        logic        p;
    } ent_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    ent_t        q[$];
    logic        exp_get = 1'b0;
    ent_t        exp_out = '0;
    logic [31:0] pc_seq  = 32'h0;

    instruction_queue_if bus();

    instruction_queue #(.ISQ_DEPTH(DEPTH)) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .isq      (bus)
    );

    always #5 clk = ~clk;

    task automatic check(string tag, logic [31:0] got, logic [31:0] expv);
        total++;
        assert (got === expv) else begin
            bad++;
            $error("FAIL %s: got=%h exp=%h t=%0t", tag, got, expv, $time);
        end
    endtask

    task automatic check_all(string tag);
        check({tag, ".get"},  32'(bus.get_instruction), 32'(exp_get));
        check({tag, ".ins"},  bus.isq_ins_out, exp_out.ins);
        check({tag, ".pc"},   bus.isq_pc_out, exp_out.pc);
        check({tag, ".pred"}, 32'(bus.isq_pc_predict), 32'(exp_out.p));
        check({tag, ".full"}, 32'(bus.isq_full), 32'(q.size() >= DEPTH - 1));
        $display("%s: get=%0b pc=%h full=%0b depth=%0d", tag, bus.get_instruction,
                 bus.isq_pc_out, bus.isq_full, q.size());
    endtask

    // Model: FIFO of entries; one pop per cycle when downstream is free, push after pop decision.
    task automatic step(string tag);
        ent_t f;
        bit   bp, iss, byp;
        int   n;
        f = '{bus.fetch_ins, bus.fetch_pc, bus.fetch_pc_predict};
        if (rst_n && bus.rdy_in) begin
            if (bus.roll_back) begin
                q.delete();
                exp_get = 1'b0;
            end else begin
                n   = q.size();
                bp  = bus.rob_is_full || bus.rs_is_full || bus.lsb_is_full;
                iss = (n > 0) && !bp;
                byp = 1'b0;
`ifdef ISQ_BYPASS_EN
                byp = (n == 0) && bus.fetch_valid && !bp;
`endif
                exp_get = iss || byp;
                if (iss) exp_out = q.pop_front();
                else if (byp) exp_out = f;
                if (bus.fetch_valid && !byp && (n < DEPTH || iss)) q.push_back(f);
            end
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic set_fetch(bit v);
        bus.fetch_valid      = v;
        bus.fetch_pc         = pc_seq;
        bus.fetch_ins        = $urandom;
        bus.fetch_pc_predict = 1'($urandom_range(1));
        if (v) pc_seq += 32'd4;
    endtask

    task automatic set_bp(bit rob, bit rs, bit lsb);
        bus.rob_is_full = rob;
        bus.rs_is_full  = rs;
        bus.lsb_is_full = lsb;
    endtask

    initial begin
        bus.rdy_in    = 1'b1;
        bus.roll_back = 1'b0;
        set_bp(0, 0, 0);
        set_fetch(0);

        // Reset values while held in reset.
        #1;
        check_all("reset0");
        step("reset1");
        @(negedge clk);
        rst_n = 1'b1;

        // Three pushes, free downstream: pulses in order with pc 0,4,8.
        for (int i = 0; i < 3; i++) begin
            set_fetch(1);
            step("basic_push");
        end
        set_fetch(0);
        for (int i = 0; i < 4; i++) step("basic_drain");

        // Fill under back-pressure: 17 pushes, the last dropped.
        pc_seq = 32'h1000;
        set_bp(1, 0, 0);
        for (int i = 0; i < 17; i++) begin
            set_fetch(1);
            step("fill");
        end
        set_fetch(0);
        set_bp(0, 0, 0);
        for (int i = 0; i < 18; i++) step("fill_drain");

        // Full queue, push and issue together for 40 cycles.
        pc_seq = 32'h2000;
        set_bp(0, 1, 0);
        for (int i = 0; i < 16; i++) begin
            set_fetch(1);
            step("stream_fill");
        end
        set_bp(0, 0, 0);
        for (int i = 0; i < 40; i++) begin
            set_fetch(1);
            step("stream");
        end
        set_fetch(0);
        for (int i = 0; i < 18; i++) step("stream_drain");

        // Roll back five queued entries with a simultaneous push.
        pc_seq = 32'h3000;
        set_bp(0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            set_fetch(1);
            step("rb_fill");
        end
        bus.roll_back = 1'b1;
        set_fetch(1);
        step("rb_flush");
        bus.roll_back = 1'b0;
        set_bp(0, 0, 0);
        pc_seq = 32'h100;
        set_fetch(1);
        step("rb_push");
        set_fetch(0);
        for (int i = 0; i < 3; i++) step("rb_drain");

        // Pause with entries queued; roll_back and fetch ignored while paused.
        pc_seq = 32'h4000;
        set_bp(1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            set_fetch(1);
            step("pause_fill");
        end
        set_fetch(0);
        set_bp(0, 0, 0);
        step("pause_issue");
        bus.rdy_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.roll_back = (i == 1);
            set_fetch(1);
            step("paused");
        end
        bus.roll_back = 1'b0;
        bus.rdy_in    = 1'b1;
        set_fetch(0);
        for (int i = 0; i < 5; i++) step("resume");

        // Random traffic.
        pc_seq = 32'h8000;
        for (int i = 0; i < 400; i++) begin
            bus.rdy_in    = ($urandom_range(9) != 0);
            bus.roll_back = ($urandom_range(39) == 0);
            set_bp($urandom_range(3) == 0, $urandom_range(5) == 0, $urandom_range(5) == 0);
            set_fetch($urandom_range(9) < 7);
            step("rand");
        end
        bus.rdy_in    = 1'b1;
        bus.roll_back = 1'b0;

        // Asynchronous reset between edges with seven entries buffered.
        pc_seq = 32'h5000;
        set_bp(1, 1, 0);
        for (int i = 0; i < 7; i++) begin
            set_fetch(1);
            step("ar_fill");
        end
        set_fetch(0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        q.delete();
        exp_get = 1'b0;
        exp_out = '0;
        check_all("ar_async");
        step("ar_held");
        @(negedge clk);
        rst_n = 1'b1;
        set_bp(0, 0, 0);
        pc_seq = 32'h6000;
        set_fetch(1);
        step("ar_push");
        set_fetch(0);
        for (int i = 0; i < 3; i++) step("ar_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
